ptp_tsq_reader: RTL
===================

Name: ptp_tsq_reader

Overview:
- Host-side bus master that drains the RX and TX timestamp queues of the ha1588 core through its register slave port (wr/rd/addr/data).
- Polls each queue's status word and pops one entry when one is pending. Reads the 128-bit entry as four 32-bit words.
- Presents the entry on a valid/ready stream tagged RX or TX, so an on-chip consumer gets timestamps without a CPU.
- Sits on the same clk domain as the ha1588 register port.

Parameters:
- RD_LAT, 1, cycles from rd_out pulse to data_in valid (1..3).
- POP_SETTLE, 2, idle cycles after the pop write before the first data read.
- POLL_GAP, 16, idle cycles between successive status polls when both queues are empty.
- QCTRL_ADDR, 8'h40, byte address of the queue-control register.
- RXQ_STAT_ADDR, 8'h44, byte address of the RX status word; data_in[7:0] is the entry count.
- RXQ_DATA_ADDR, 8'h48, base byte address of the four RX data words.
- TXQ_STAT_ADDR, 8'h64, byte address of the TX status word.
- TXQ_DATA_ADDR, 8'h68, base byte address of the four TX data words.
- RX_POP_VAL, 32'h1, value written to QCTRL_ADDR to pop the RX queue.
- TX_POP_VAL, 32'h2, value written to QCTRL_ADDR to pop the TX queue.

Ports:
- clk, in, 1, single clock for all logic.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, enables polling; sampled only in IDLE.
- wr_out, out, 1, single-cycle register write strobe.
- rd_out, out, 1, single-cycle register read strobe.
- addr_out, out, 8, byte address; bits [1:0] are always 0.
- data_out, out, 32, write data; valid only while wr_out=1.
- data_in, in, 32, read data from the ha1588 register port.
- ts_valid, out, 1, timestamp entry available.
- ts_ready, in, 1, consumer accepts the entry.
- ts_data, out, 128, entry; word at DATA_ADDR+0 maps to [127:96], +4 to [95:64], +8 to [63:32], +C to [31:0].
- ts_dir, out, 1, 0 = RX queue, 1 = TX queue.
- busy, out, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, async): FSM to IDLE. wr_out, rd_out, ts_valid, busy and ts_dir are 0. addr_out, data_out and ts_data are 0. Gap counter is 0. Round-robin pointer selects RX.
- Bus rules: at most one of wr_out/rd_out is high in any cycle. Every strobe lasts exactly one cycle. addr_out and data_out are registered with the strobe. data_in is captured exactly RD_LAT cycles after the rd_out cycle.
- IDLE: if en=1 and the gap counter is 0, go to STAT_RD with the queue selected by the round-robin pointer. Otherwise decrement the gap counter (saturates at 0).
- STAT_RD: issue rd_out at the STAT_ADDR of the selected queue. Go to STAT_WAIT.
- STAT_WAIT: wait RD_LAT cycles, then capture data_in[7:0].
  - Count nonzero: go to POP_WR.
  - Count zero, other queue not yet polled this round: toggle the pointer, go to STAT_RD.
  - Count zero, both queues empty this round: load the gap counter with POLL_GAP, go to IDLE.
- POP_WR: assert wr_out with addr_out=QCTRL_ADDR and data_out=RX_POP_VAL or TX_POP_VAL. Go to SETTLE.
- SETTLE: wait POP_SETTLE cycles, then go to DATA_RD with word index 0.
- DATA_RD / DATA_WAIT: for index 0..3, issue rd_out at DATA_ADDR+4*index. Wait RD_LAT cycles and load the word into the ts_data slice, then go to the next index. After index 3, go to OUT.
- OUT: ts_valid=1, with ts_dir set to the queue read. ts_data and ts_dir are held stable while ts_valid=1 and ts_ready=0.
  - Handshake: the transfer occurs on a cycle with ts_valid=1 and ts_ready=1. On the next cycle ts_valid=0.
  - After the transfer, toggle the pointer (fairness) and go directly to STAT_RD with gap 0.
- Back-pressure: no new bus access is issued while in OUT, so no entry is ever popped without a free output slot.
- en dropping mid-transaction: the current entry completes and is delivered. The FSM then goes to IDLE and stays there while en=0.
- Latency: the first rd_out appears 1 cycle after IDLE sees en=1 with gap 0. With RD_LAT=1 and POP_SETTLE=2, ts_valid rises 15 cycles after the first stat rd_out when the first queue is non-empty.
- Count saturation is irrelevant to this block; only zero vs. nonzero is used.

Test Plan:
- Reset mid-transfer: assert rst during DATA_WAIT index 2 -> all outputs 0 within the same cycle. After release with en=1, the first access is a rd_out at 8'h44.
- RX pending: RX stat count=3, RX words 32'hAAAA0001..32'hAAAA0004, ts_ready=1.
  - Required bus sequence: rd 8'h44, wr 8'h40 with data 32'h1, rd 8'h48, rd 8'h4C, rd 8'h50, rd 8'h54.
  - Required output: ts_data=128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004, ts_dir=0.
- Both empty: both stat counts=0 -> reads of 8'h44 then 8'h64, then exactly 16 idle cycles, then rd 8'h44 again. No wr_out at any point.
- Fairness: both queues always non-empty -> output ts_dir alternates 0,1,0,1 over 4 entries.
- Back-pressure: hold ts_ready=0 for 50 cycles in OUT -> ts_valid stays 1, ts_data is unchanged, and no rd_out/wr_out is issued. Releasing ts_ready gives exactly one transfer.
- RD_LAT=3 build: data is captured 3 cycles after each rd_out, and the entry is still assembled correctly.

Source files
------------

// File: rtl/ptp_tsq_reader.sv
// ptp_tsq_reader
// Bus master that drains the ha1588 RX/TX timestamp queues through the
// register slave port and hands each 128-bit entry to an on-chip consumer
// over a valid/ready stream tagged with the queue it came from.
module ptp_tsq_reader #(
  parameter int unsigned  RD_LAT        = 1,
  parameter int unsigned  POP_SETTLE    = 2,
  parameter int unsigned  POLL_GAP      = 16,
  parameter logic [7:0]   QCTRL_ADDR    = 8'h40,
  parameter logic [7:0]   RXQ_STAT_ADDR = 8'h44,
  parameter logic [7:0]   RXQ_DATA_ADDR = 8'h48,
  parameter logic [7:0]   TXQ_STAT_ADDR = 8'h64,
  parameter logic [7:0]   TXQ_DATA_ADDR = 8'h68,
  parameter logic [31:0]  RX_POP_VAL    = 32'h1,
  parameter logic [31:0]  TX_POP_VAL    = 32'h2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          wr_out,
  output logic          rd_out,
  output logic [7:0]    addr_out,
  output logic [31:0]   data_out,
  input  logic [31:0]   data_in,
  output logic          ts_valid,
  input  logic          ts_ready,
  output logic [127:0]  ts_data,
  output logic          ts_dir,
  output logic          busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_STAT_RD   = 4'd1;
  localparam logic [3:0] S_STAT_WAIT = 4'd2;
  localparam logic [3:0] S_STAT_CHK  = 4'd3;
  localparam logic [3:0] S_POP_WR    = 4'd4;
  localparam logic [3:0] S_SETTLE    = 4'd5;
  localparam logic [3:0] S_DATA_RD   = 4'd6;
  localparam logic [3:0] S_DATA_WAIT = 4'd7;
  localparam logic [3:0] S_OUT       = 4'd8;

  // Counters are loaded with "cycles - 1" so the state ends on the
  // cycle where the counter reads zero.
  localparam logic [7:0]  LP_RD_WAIT = 8'(RD_LAT - 1);
  localparam logic [7:0]  LP_SETTLE  = 8'(POP_SETTLE - 1);
  // The IDLE cycle that sees gap==0 is itself one of the idle cycles,
  // so loading POLL_GAP-1 gives exactly POLL_GAP cycles with busy low.
  localparam logic [15:0] LP_GAP     = 16'(POLL_GAP - 1);

  logic [3:0]   r_state;
  logic         r_ptr;          // 0 = RX queue selected, 1 = TX queue
  logic         r_other_done;   // other queue already polled this round
  logic         r_stat_nz;
  logic [7:0]   r_cnt;
  logic [1:0]   r_idx;
  logic [15:0]  r_gap;
  logic         r_wr;
  logic         r_rd;
  logic [7:0]   r_addr;
  logic [31:0]  r_wdata;
  logic         r_ts_valid;
  logic [127:0] r_ts_data;
  logic         r_ts_dir;
  logic         r_busy;

  logic [7:0]   w_stat_cur;
  logic [7:0]   w_stat_oth;
  logic [7:0]   w_data_base;
  logic [31:0]  w_pop_val;
  logic [1:0]   w_idx_nxt;
  logic [7:0]   w_data_addr_nxt;

  assign w_stat_cur      = r_ptr ? TXQ_STAT_ADDR : RXQ_STAT_ADDR;
  assign w_stat_oth      = r_ptr ? RXQ_STAT_ADDR : TXQ_STAT_ADDR;
  assign w_data_base     = r_ptr ? TXQ_DATA_ADDR : RXQ_DATA_ADDR;
  assign w_pop_val       = r_ptr ? TX_POP_VAL : RX_POP_VAL;
  assign w_idx_nxt       = r_idx + 2'd1;
  assign w_data_addr_nxt = w_data_base + {4'd0, w_idx_nxt, 2'b00};

  // Polling / pop / read-out sequencer; strobes are set on the edge that
  // enters the issuing state so they are high for exactly that state cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_other_done <= 1'b0;
      r_stat_nz    <= 1'b0;
      r_cnt        <= 8'd0;
      r_idx        <= 2'd0;
      r_gap        <= 16'd0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_addr       <= 8'd0;
      r_wdata      <= 32'd0;
      r_ts_valid   <= 1'b0;
      r_ts_data    <= 128'd0;
      r_ts_dir     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en && (r_gap == 16'd0)) begin
            r_state      <= S_STAT_RD;
            r_rd         <= 1'b1;
            r_addr       <= w_stat_cur;
            r_busy       <= 1'b1;
            r_other_done <= 1'b0;
          end else if (r_gap != 16'd0) begin
            r_gap <= r_gap - 16'd1;
          end else begin
            r_gap <= 16'd0;
          end
        end
        S_STAT_RD: begin
          r_rd    <= 1'b0;
          r_addr  <= 8'd0;
          r_cnt   <= LP_RD_WAIT;
          r_state <= S_STAT_WAIT;
        end
        S_STAT_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_stat_nz <= |data_in[7:0];
            r_state   <= S_STAT_CHK;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_STAT_CHK: begin
          if (r_stat_nz) begin
            r_state <= S_POP_WR;
            r_wr    <= 1'b1;
            r_addr  <= QCTRL_ADDR;
            r_wdata <= w_pop_val;
          end else if (!r_other_done) begin
            r_ptr        <= ~r_ptr;
            r_other_done <= 1'b1;
            r_state      <= S_STAT_RD;
            r_rd         <= 1'b1;
            r_addr       <= w_stat_oth;
          end else begin
            // Both empty: flip back so every round starts on the same queue.
            r_ptr   <= ~r_ptr;
            r_gap   <= LP_GAP;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_POP_WR: begin
          r_wr    <= 1'b0;
          r_addr  <= 8'd0;
          r_wdata <= 32'd0;
          r_cnt   <= LP_SETTLE;
          r_idx   <= 2'd0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_rd    <= 1'b1;
            r_addr  <= w_data_base;
            r_state <= S_DATA_RD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DATA_RD: begin
          r_rd    <= 1'b0;
          r_addr  <= 8'd0;
          r_cnt   <= LP_RD_WAIT;
          r_state <= S_DATA_WAIT;
        end
        S_DATA_WAIT: begin
          if (r_cnt == 8'd0) begin
            case (r_idx)
              2'd0:    r_ts_data[127:96] <= data_in;
              2'd1:    r_ts_data[95:64]  <= data_in;
              2'd2:    r_ts_data[63:32]  <= data_in;
              2'd3:    r_ts_data[31:0]   <= data_in;
              default: r_ts_data[31:0]   <= data_in;
            endcase
            if (r_idx == 2'd3) begin
              r_ts_dir <= r_ptr;
              r_state  <= S_OUT;
            end else begin
              r_idx   <= w_idx_nxt;
              r_rd    <= 1'b1;
              r_addr  <= w_data_addr_nxt;
              r_state <= S_DATA_RD;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_OUT: begin
          // First OUT cycle commits the assembled entry; then hold until taken.
          if (!r_ts_valid) begin
            r_ts_valid <= 1'b1;
          end else if (ts_ready) begin
            r_ts_valid   <= 1'b0;
            r_ptr        <= ~r_ptr;
            r_other_done <= 1'b0;
            r_gap        <= 16'd0;
            if (en) begin
              r_state <= S_STAT_RD;
              r_rd    <= 1'b1;
              r_addr  <= w_stat_oth;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_ts_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_wr       <= 1'b0;
          r_rd       <= 1'b0;
          r_addr     <= 8'd0;
          r_wdata    <= 32'd0;
          r_ts_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_out   = r_wr;
  assign rd_out   = r_rd;
  assign addr_out = r_addr;
  assign data_out = r_wdata;
  assign ts_valid = r_ts_valid;
  assign ts_data  = r_ts_data;
  assign ts_dir   = r_ts_dir;
  assign busy     = r_busy;

endmodule
